switch_debouncer: RTL
=====================

# switch_debouncer

Front-end conditioning stage for slide switches and push buttons on the BASYS 3 board. Each raw pad input is synchronised into the system clock domain and debounced. A clean level and single-cycle edge strobes are produced per channel. The block sits directly between the board pins and the combinational logic-gate demonstration stages, which consume its debounced levels in place of raw switch inputs.

## Interface

Parameters:
- NUM_CH, default 2: number of independent input channels; must be ≥1.
- STABLE_CYCLES, default 1_000_000: consecutive clock cycles a new synchronised level must hold before it is accepted. The default is 10 ms at 100 MHz. Must be ≥1.

Ports:
- I_P_CLK  input  1  system clock, 100 MHz.
- I_P_RST_N  input  1  reset. Asynchronous assert, active-low; applies to all state.
- I_P_RAW  input  NUM_CH  raw asynchronous switch/button levels, one bit per channel.
- O_P_DB  output  NUM_CH  debounced level per channel.
- O_P_RISE  output  NUM_CH  one-cycle strobe when O_P_DB[i] goes 0→1.
- O_P_FALL  output  NUM_CH  one-cycle strobe when O_P_DB[i] goes 1→0.

## Operation

- Every channel is independent and identical.
- Synchroniser: two flops per channel, sync1 then sync2. Only sync2 is used downstream.
- Per-channel counter cnt, width CNT_W = $clog2(STABLE_CYCLES+1).
- Per-channel FSM, two states:
  - IDLE: sync2 == O_P_DB and cnt == 0.
  - PENDING: sync2 != O_P_DB, and cnt counts the cycles of disagreement.
- Each clock edge:
  - If sync2 == O_P_DB: cnt ← 0, state ← IDLE. Any partially counted bounce is discarded.
  - If sync2 != O_P_DB and cnt < STABLE_CYCLES-1: cnt ← cnt+1, state ← PENDING.
  - If sync2 != O_P_DB and cnt == STABLE_CYCLES-1:
    - O_P_DB ← sync2 and cnt ← 0.
    - O_P_RISE or O_P_FALL ← 1 for this single cycle, matching the direction of the change.
    - state ← IDLE.
- O_P_RISE and O_P_FALL are 0 in every other cycle. They are never both 1 on the same channel.
- The counter never exceeds STABLE_CYCLES-1, so no wrap-around is possible.
- STABLE_CYCLES = 1: a change is accepted on the first cycle sync2 differs from O_P_DB.

## Timing

- Reset values, all channels: sync1 = sync2 = 0, cnt = 0, O_P_DB = 0, O_P_RISE = 0, O_P_FALL = 0.
- If a pad is already 1 at reset release, O_P_DB reaches 1 after the full latency and produces one O_P_RISE pulse. This is the required behaviour.
- Latency: a clean input step first sampled on edge k appears on O_P_DB, with its strobe, on edge k+1+STABLE_CYCLES. That is STABLE_CYCLES+2 edges counted from the edge preceding k.
- Any return of sync2 to O_P_DB before acceptance restarts the count from 0. A pulse of up to STABLE_CYCLES-1 synchronised cycles causes no output change.
- All outputs are registered, with no combinational path from I_P_RAW to any output.
- Reset asserted mid-count clears everything immediately and asynchronously; no strobe is emitted.
- Throughput: at most one accepted transition per channel per STABLE_CYCLES cycles.

## Structure

- Shared package board_io_pkg holds:
  - CLK_HZ = 100_000_000.
  - DEBOUNCE_MS = 10.
  - Derived DEBOUNCE_CYCLES, used by top-level instantiations for STABLE_CYCLES.
  - Debounce FSM state enum {IDLE, PENDING}.
- Sub-module debounce_channel implements one channel: synchroniser, counter, FSM and edge strobes. It takes the same STABLE_CYCLES parameter.
- switch_debouncer instantiates NUM_CH copies in a generate loop.

## Test plan

All scenarios use NUM_CH=2 and STABLE_CYCLES=4.

- Reset check: hold I_P_RST_N=0 with I_P_RAW=2'b11, then release. O_P_DB[1:0] must equal 2'b00 during reset. It must become 2'b11 exactly 6 edges after release, with O_P_RISE=2'b11 for exactly one cycle.
- Clean step: raise I_P_RAW[0] at edge k. O_P_DB[0] must go 1 on edge k+5, with O_P_RISE[0] high only in that cycle. Channel 1 must stay unchanged.
- Bounce rejection: toggle I_P_RAW[0] with pattern 1,1,1,0,1,1,0 (each value held one cycle), then hold 0. O_P_DB[0] must stay 0 throughout, with no strobe.
- Bounce then settle: apply pattern 1,0,1,1,1,1 and hold 1. O_P_DB[0] must rise exactly 5 edges after the last 0→1 sample.
- Falling edge and independence: with both channels at 1, drop I_P_RAW[1] while I_P_RAW[0] bounces. Only O_P_FALL[1] must pulse, once.
- Reset mid-count: assert reset 2 cycles into PENDING. All outputs must be 0 immediately, with no strobe after release while the input is 0.

Source files
------------

// File: rtl/board_io_pkg.sv
// -----------------------------------------------------------------------------
// board_io_pkg
//   Shared constants and types for the BASYS 3 board I/O conditioning stages.
//
//   CLK_HZ          : system clock frequency in Hz.
//   DEBOUNCE_MS     : settling time a switch level must hold before acceptance.
//   DEBOUNCE_CYCLES : DEBOUNCE_MS expressed in system clock cycles; top-level
//                     instantiations pass this as STABLE_CYCLES.
//   db_state_e      : per-channel debounce FSM state.
// -----------------------------------------------------------------------------
package board_io_pkg;

    localparam int unsigned CLK_HZ          = 100_000_000;
    localparam int unsigned DEBOUNCE_MS     = 10;
    localparam int unsigned DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;

    // IDLE    : synchronised input agrees with the debounced level, counter at 0.
    // PENDING : synchronised input disagrees, counter tracks how long it has.
    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } db_state_e;

endpackage

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
//   One switch/button channel: two-flop synchroniser, disagreement counter,
//   two-state debounce FSM and registered rise/fall strobes.
//
//   Parameters
//     STABLE_CYCLES : consecutive cycles a new synchronised level must hold
//                     before it is accepted (>= 1).
//   Ports
//     i_clk   : system clock.
//     i_rst_n : asynchronous active-low reset, clears all state.
//     i_raw   : raw asynchronous pad level.
//     o_db    : debounced level (registered).
//     o_rise  : one-cycle strobe coincident with o_db going 0->1 (registered).
//     o_fall  : one-cycle strobe coincident with o_db going 1->0 (registered).
// -----------------------------------------------------------------------------
module debounce_channel
    import board_io_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEBOUNCE_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_db,
    output logic o_rise,
    output logic o_fall
);

    localparam int unsigned      CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    // With a one-cycle window a change is accepted straight out of IDLE.
    localparam bit               ACCEPT_IMMEDIATE = (STABLE_CYCLES == 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_d;
    db_state_e        r_state;
    db_state_e        w_state_d;
    logic             r_db;
    logic             w_db_d;
    logic             r_rise;
    logic             w_rise_d;
    logic             r_fall;
    logic             w_fall_d;
    logic             w_differ;
    logic             w_accept;

    // Synchroniser: only r_sync2 is allowed to feed logic.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_differ = (r_sync2 != r_db);

    // Next-state, counter and strobe logic.
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_db_d    = r_db;
        w_rise_d  = 1'b0;
        w_fall_d  = 1'b0;
        w_accept  = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (w_differ) begin
                    if (ACCEPT_IMMEDIATE) begin
                        w_accept = 1'b1;
                    end else begin
                        // First disagreeing cycle; counter is 0 in IDLE.
                        w_cnt_d   = CNT_W'(1);
                        w_state_d = PENDING;
                    end
                end else begin
                    w_cnt_d = '0;
                end
            end
            PENDING: begin
                if (!w_differ) begin
                    // Bounced back before acceptance: discard the partial count.
                    w_cnt_d   = '0;
                    w_state_d = IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_accept = 1'b1;
                end else begin
                    w_cnt_d = r_cnt + CNT_W'(1);
                end
            end
        endcase

        if (w_accept) begin
            w_db_d    = r_sync2;
            w_rise_d  = r_sync2;
            w_fall_d  = ~r_sync2;
            w_cnt_d   = '0;
            w_state_d = IDLE;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_db    <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_db    <= w_db_d;
            r_rise  <= w_rise_d;
            r_fall  <= w_fall_d;
        end
    end

    assign o_db   = r_db;
    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: rtl/switch_debouncer.sv
// -----------------------------------------------------------------------------
// switch_debouncer
//   Front-end conditioning for BASYS 3 slide switches and push buttons. Each
//   raw pad bit is synchronised and debounced independently; a clean level and
//   single-cycle rise/fall strobes are produced per channel. All outputs are
//   registered.
//
//   Parameters
//     NUM_CH        : number of independent channels (>= 1).
//     STABLE_CYCLES : cycles a new level must hold before acceptance (>= 1).
//   Ports
//     I_P_CLK   : 100 MHz system clock.
//     I_P_RST_N : asynchronous active-low reset.
//     I_P_RAW   : raw asynchronous pad levels, one bit per channel.
//     O_P_DB    : debounced levels.
//     O_P_RISE  : per-channel one-cycle strobe on O_P_DB 0->1.
//     O_P_FALL  : per-channel one-cycle strobe on O_P_DB 1->0.
// -----------------------------------------------------------------------------
module switch_debouncer
    import board_io_pkg::*;
#(
    parameter int unsigned NUM_CH        = 2,
    parameter int unsigned STABLE_CYCLES = DEBOUNCE_CYCLES
) (
    input  logic              I_P_CLK,
    input  logic              I_P_RST_N,
    input  logic [NUM_CH-1:0] I_P_RAW,
    output logic [NUM_CH-1:0] O_P_DB,
    output logic [NUM_CH-1:0] O_P_RISE,
    output logic [NUM_CH-1:0] O_P_FALL
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_channel (
            .i_clk  (I_P_CLK),
            .i_rst_n(I_P_RST_N),
            .i_raw  (I_P_RAW[g]),
            .o_db   (O_P_DB[g]),
            .o_rise (O_P_RISE[g]),
            .o_fall (O_P_FALL[g])
        );
    end

endmodule
